rotate_tile_seq: RTL and testbench
==================================

ROTATE_TILE_SEQ -- requirements
Module: rotate_tile_seq

Interface
REQ-001 Parameter P_TILE, 8, tile edge in pixels.
REQ-002 Parameter P_BPP, 3, bytes per pixel (R,G,B).
REQ-003 I_TS_HCLK  in  1  sole clock; all state on rising edge.
REQ-004 I_TS_HRESET  in  1  asynchronous, active-high reset.
REQ-005 I_TS_START  in  1  job start pulse; I_TS_WIDTH/I_TS_HEIGHT in 16 image size in pixels; I_TS_DEGREES in 2 (0/90/180/270); I_TS_DIRECTION in 1 (1=counter-clockwise).
REQ-006 I_TS_SRC_BASE, I_TS_DST_BASE  in  32  frame byte base addresses; I_TS_IRQ_CLR  in  1  clears IRQ.
REQ-007 O_TS_RD_REQ out 1 / O_TS_RD_ADDR out 32 / I_TS_RD_DONE in 1: source tile fetch handshake to AHB master.
REQ-008 O_TS_CORE_START out 1 / O_TS_CORE_DEGREES out 2 / O_TS_CORE_DIRECTION out 1 / I_TS_CORE_DONE in 1: pixel-core handshake.
REQ-009 O_TS_WR_REQ out 1 / O_TS_WR_ADDR out 32 / I_TS_WR_DONE in 1: rotated tile store handshake.
REQ-010 O_TS_BUSY, O_TS_IRQ, O_TS_ERR out 1 each; O_TS_TILE_X, O_TS_TILE_Y out 8 current source tile column/row.

Function
REQ-011 FSM states IDLE, RD, ROT, WR, ADV; encoding 3 bits; BUSY=1 in every state except IDLE.
REQ-012 IDLE: START=1 with valid config -> latch all config inputs, clear tile counters, go RD next cycle; config inputs ignored thereafter until IDLE.
REQ-013 Valid config: WIDTH and HEIGHT nonzero, multiples of 8, each <= 2040; otherwise ERR set, stay IDLE, no REQ issued; ERR cleared by next valid START.
REQ-014 RD: RD_REQ=1 with stable RD_ADDR until RD_DONE sampled 1; next cycle ROT, RD_REQ=0.
REQ-015 ROT: CORE_START=1 for exactly first cycle of ROT; wait CORE_DONE -> WR next cycle.
REQ-016 WR: WR_REQ=1 with stable WR_ADDR until WR_DONE sampled 1 -> ADV next cycle.
REQ-017 ADV (1 cycle): if last tile -> IDLE, IRQ set; else TX++, on TX=TW-1 wrap TX=0 and TY++; -> RD.
REQ-018 TW=WIDTH/8, TH=HEIGHT/8; tiles processed raster order, TW*TH tiles total.
REQ-019 Effective clockwise amount r = DIRECTION ? (4-DEGREES) mod 4 : DEGREES; CORE_DEGREES/CORE_DIRECTION drive latched raw values.
REQ-020 Dest tile (DX,DY): r0 (TX,TY); r1 (TH-1-TY,TX); r2 (TW-1-TX,TH-1-TY); r3 (TY,TW-1-TX); dest width DW = r odd ? HEIGHT : WIDTH.
REQ-021 RD_ADDR = SRC_BASE + (TY*8*WIDTH + TX*8)*3; WR_ADDR = DST_BASE + (DY*8*DW + DX*8)*3; modulo 2^32, registered, valid from state entry.
REQ-022 RD_DONE, CORE_DONE, WR_DONE ignored outside their own state; START ignored while BUSY.
REQ-023 IRQ level, held until IRQ_CLR; set and clear in same cycle -> set wins.
REQ-024 Single-tile image (8x8): RD, ROT, WR, ADV once, then IDLE with IRQ.

Reset
REQ-025 HRESET=1 asynchronously forces IDLE; all outputs 0, counters 0, latched config 0, IRQ/ERR 0.
REQ-026 Reset mid-job abandons job without IRQ; REQ outputs drop immediately.

Structure
REQ-027 Shared package holds FSM state codes, degree codes (P_DEG_0..P_DEG_270), P_TILE, P_BPP.
REQ-028 One sub-module rotate_tile_map: combinational (TX,TY,TW,TH,r) -> (DX,DY,DW) per REQ-020.

Verification
REQ-029 16x16, DEG0 CW, SRC_BASE=0x1000, DONEs after 2 cycles -> RD_ADDR 0x1000, 0x1018, 0x1180, 0x1198; WR_ADDR equal with DST_BASE; IRQ after 4th ADV.
REQ-030 16x8, DEG 90 CW, DST_BASE=0 -> WR_ADDR 0 then 192 (0xC0).
REQ-031 16x8, DEG 90 CCW -> WR_ADDR 192 then 0; CORE_DIRECTION=1, CORE_DEGREES=1.
REQ-032 WIDTH=12, START -> ERR=1, BUSY=0, RD_REQ never asserted; then valid START -> ERR=0.
REQ-033 Reset asserted during ROT of tile 2 -> all outputs 0 same cycle, IRQ=0; new START restarts from tile (0,0).
REQ-034 IRQ_CLR held high through final ADV -> IRQ=1 next cycle; one later cycle of IRQ_CLR -> IRQ=0.

Source files
------------

// File: rtl/rotate_tile_seq_pkg.sv
// Shared definitions for the tile rotation sequencer: FSM state codes,
// rotation degree codes and tile geometry constants.
package rotate_tile_seq_pkg;

    localparam int P_TILE = 8;
    localparam int P_BPP  = 3;

    localparam logic [1:0] P_DEG_0   = 2'd0;
    localparam logic [1:0] P_DEG_90  = 2'd1;
    localparam logic [1:0] P_DEG_180 = 2'd2;
    localparam logic [1:0] P_DEG_270 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_ROT  = 3'd2,
        ST_WR   = 3'd3,
        ST_ADV  = 3'd4
    } state_e;

    // Counter-clockwise turns are folded into the equivalent clockwise count.
    function automatic logic [1:0] eff_rot(input logic [1:0] deg, input logic dir);
        return dir ? 2'(2'd0 - deg) : deg;
    endfunction

endpackage

// File: rtl/rotate_tile_seq_if.sv
// Fetch, pixel-core and store handshakes between the sequencer (master)
// and the AHB master / rotation core (slave).
interface rotate_tile_seq_if;

    logic        O_TS_RD_REQ;
    logic [31:0] O_TS_RD_ADDR;
    logic        I_TS_RD_DONE;

    logic        O_TS_CORE_START;
    logic [1:0]  O_TS_CORE_DEGREES;
    logic        O_TS_CORE_DIRECTION;
    logic        I_TS_CORE_DONE;

    logic        O_TS_WR_REQ;
    logic [31:0] O_TS_WR_ADDR;
    logic        I_TS_WR_DONE;

    modport master (
        output O_TS_RD_REQ, O_TS_RD_ADDR,
        input  I_TS_RD_DONE,
        output O_TS_CORE_START, O_TS_CORE_DEGREES, O_TS_CORE_DIRECTION,
        input  I_TS_CORE_DONE,
        output O_TS_WR_REQ, O_TS_WR_ADDR,
        input  I_TS_WR_DONE
    );

    modport slave (
        input  O_TS_RD_REQ, O_TS_RD_ADDR,
        output I_TS_RD_DONE,
        input  O_TS_CORE_START, O_TS_CORE_DEGREES, O_TS_CORE_DIRECTION,
        output I_TS_CORE_DONE,
        input  O_TS_WR_REQ, O_TS_WR_ADDR,
        output I_TS_WR_DONE
    );

endinterface

// File: rtl/rotate_tile_seq_map.sv
// Maps a source tile position to its destination tile position and the
// destination frame width for a given clockwise quarter-turn count.
module rotate_tile_map
    import rotate_tile_seq_pkg::*;
(
    input  logic [7:0]  tx_i,
    input  logic [7:0]  ty_i,
    input  logic [7:0]  tw_i,
    input  logic [7:0]  th_i,
    input  logic [1:0]  rot_i,
    input  logic [15:0] width_i,
    input  logic [15:0] height_i,
    output logic [7:0]  dx_o,
    output logic [7:0]  dy_o,
    output logic [15:0] dw_o
);

    always_comb begin
        dx_o = tx_i;
        dy_o = ty_i;
        dw_o = width_i;
        case (rot_i)
            P_DEG_90: begin
                dx_o = th_i - 8'd1 - ty_i;
                dy_o = tx_i;
                dw_o = height_i;
            end
            P_DEG_180: begin
                dx_o = tw_i - 8'd1 - tx_i;
                dy_o = th_i - 8'd1 - ty_i;
            end
            P_DEG_270: begin
                dx_o = ty_i;
                dy_o = tw_i - 8'd1 - tx_i;
                dw_o = height_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rotate_tile_seq.sv
// Tile rotation sequencer: walks the source image tile by tile in raster
// order, fetching, rotating and storing each tile, then raises IRQ.
module rotate_tile_seq #(
    parameter int P_TILE = rotate_tile_seq_pkg::P_TILE,
    parameter int P_BPP  = rotate_tile_seq_pkg::P_BPP
) (
    input  logic               I_TS_HCLK,
    input  logic               I_TS_HRESET,
    input  logic               I_TS_START,
    input  logic [15:0]        I_TS_WIDTH,
    input  logic [15:0]        I_TS_HEIGHT,
    input  logic [1:0]         I_TS_DEGREES,
    input  logic               I_TS_DIRECTION,
    input  logic [31:0]        I_TS_SRC_BASE,
    input  logic [31:0]        I_TS_DST_BASE,
    input  logic               I_TS_IRQ_CLR,
    output logic               O_TS_BUSY,
    output logic               O_TS_IRQ,
    output logic               O_TS_ERR,
    output logic [7:0]         O_TS_TILE_X,
    output logic [7:0]         O_TS_TILE_Y,
    rotate_tile_seq_if.master  bus
);

    import rotate_tile_seq_pkg::*;

    // Byte offset of a tile's top-left pixel in a frame of width w pixels.
    function automatic logic [31:0] tile_addr(input logic [31:0] base, input logic [7:0] x,
                                              input logic [7:0] y, input logic [15:0] w);
        logic [31:0] pix;
        pix = 32'(y) * 32'(P_TILE) * 32'(w) + 32'(x) * 32'(P_TILE);
        return base + pix * 32'(P_BPP);
    endfunction

    // Tile counters are 8 bits wide, which caps each dimension at 255 tiles.
    function automatic logic dim_ok(input logic [15:0] d);
        return (d != 16'd0) && ((d % 16'(P_TILE)) == 16'd0) && (d <= 16'(P_TILE * 255));
    endfunction

    state_e      state_q;
    logic [15:0] width_q, height_q;
    logic [1:0]  deg_q;
    logic        dir_q;
    logic [31:0] src_q, dst_q;
    logic [7:0]  tx_q, ty_q;
    logic        rd_req_q, core_start_q, wr_req_q;
    logic [31:0] rd_addr_q, wr_addr_q;
    logic        busy_q, irq_q, err_q;

    logic [7:0]  tx_d, ty_d;
    logic [31:0] rd_addr_d, wr_addr_d;
    logic [7:0]  tw, th, dx, dy;
    logic [15:0] dw;
    logic [1:0]  rot;
    logic        last_tile, irq_set, cfg_ok;

    rotate_tile_map u_map (
        .tx_i     (tx_q),
        .ty_i     (ty_q),
        .tw_i     (tw),
        .th_i     (th),
        .rot_i    (rot),
        .width_i  (width_q),
        .height_i (height_q),
        .dx_o     (dx),
        .dy_o     (dy),
        .dw_o     (dw)
    );

    always_comb begin
        tw        = 8'(width_q / 16'(P_TILE));
        th        = 8'(height_q / 16'(P_TILE));
        rot       = eff_rot(deg_q, dir_q);
        last_tile = (tx_q == tw - 8'd1) && (ty_q == th - 8'd1);
        irq_set   = (state_q == ST_ADV) && last_tile;
        cfg_ok    = dim_ok(I_TS_WIDTH) && dim_ok(I_TS_HEIGHT);
        tx_d      = tx_q + 8'd1;
        ty_d      = ty_q;
        if (tx_q == tw - 8'd1) begin
            tx_d = 8'd0;
            ty_d = ty_q + 8'd1;
        end
        rd_addr_d = tile_addr(src_q, tx_d, ty_d, width_q);
        wr_addr_d = tile_addr(dst_q, dx, dy, dw);
    end

    // Addresses are registered on the transition into RD/WR so they are
    // stable for the whole request.
    always_ff @(posedge I_TS_HCLK or posedge I_TS_HRESET) begin
        if (I_TS_HRESET) begin
            state_q      <= ST_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            deg_q        <= '0;
            dir_q        <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            tx_q         <= '0;
            ty_q         <= '0;
            rd_req_q     <= 1'b0;
            core_start_q <= 1'b0;
            wr_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            busy_q       <= 1'b0;
            irq_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            irq_q        <= irq_set | (irq_q & ~I_TS_IRQ_CLR);
            case (state_q)
                ST_IDLE: begin
                    if (I_TS_START) begin
                        if (cfg_ok) begin
                            width_q   <= I_TS_WIDTH;
                            height_q  <= I_TS_HEIGHT;
                            deg_q     <= I_TS_DEGREES;
                            dir_q     <= I_TS_DIRECTION;
                            src_q     <= I_TS_SRC_BASE;
                            dst_q     <= I_TS_DST_BASE;
                            tx_q      <= '0;
                            ty_q      <= '0;
                            rd_addr_q <= I_TS_SRC_BASE;
                            rd_req_q  <= 1'b1;
                            busy_q    <= 1'b1;
                            err_q     <= 1'b0;
                            state_q   <= ST_RD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (bus.I_TS_RD_DONE) begin
                        rd_req_q     <= 1'b0;
                        core_start_q <= 1'b1;
                        state_q      <= ST_ROT;
                    end
                end
                ST_ROT: begin
                    if (bus.I_TS_CORE_DONE) begin
                        wr_addr_q <= wr_addr_d;
                        wr_req_q  <= 1'b1;
                        state_q   <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (bus.I_TS_WR_DONE) begin
                        wr_req_q <= 1'b0;
                        state_q  <= ST_ADV;
                    end
                end
                ST_ADV: begin
                    if (last_tile) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        tx_q      <= tx_d;
                        ty_q      <= ty_d;
                        rd_addr_q <= rd_addr_d;
                        rd_req_q  <= 1'b1;
                        state_q   <= ST_RD;
                    end
                end
                default: begin
                    rd_req_q <= 1'b0;
                    wr_req_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.O_TS_RD_REQ         = rd_req_q;
    assign bus.O_TS_RD_ADDR        = rd_addr_q;
    assign bus.O_TS_CORE_START     = core_start_q;
    assign bus.O_TS_CORE_DEGREES   = deg_q;
    assign bus.O_TS_CORE_DIRECTION = dir_q;
    assign bus.O_TS_WR_REQ         = wr_req_q;
    assign bus.O_TS_WR_ADDR        = wr_addr_q;
    assign O_TS_BUSY               = busy_q;
    assign O_TS_IRQ                = irq_q;
    assign O_TS_ERR                = err_q;
    assign O_TS_TILE_X             = tx_q;
    assign O_TS_TILE_Y             = ty_q;

endmodule

// File: tb/tb_rotate_tile_seq.sv
// Bench for rotate_tile_seq: directed vector table, corner-case sequences and
// randomized jobs compared against a geometric rotation model.
module tb_rotate_tile_seq;

    typedef struct {
        int          w;
        int          h;
        logic [1:0]  deg;
        logic        dir;
        logic [31:0] src;
        logic [31:0] dst;
        int          dly;
        int          nexp;
        logic [3:0][31:0] erd;
        logic [3:0][31:0] ewr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] width = '0, height = '0;
    logic [1:0]  deg = '0;
    logic        dir = 1'b0;
    logic [31:0] src = '0, dst = '0;
    logic        irq_clr = 1'b0;
    logic        busy, irq, err;
    logic [7:0]  tile_x, tile_y;

    rotate_tile_seq_if bus ();

    rotate_tile_seq dut (
        .I_TS_HCLK      (clk),
        .I_TS_HRESET    (rst),
        .I_TS_START     (start),
        .I_TS_WIDTH     (width),
        .I_TS_HEIGHT    (height),
        .I_TS_DEGREES   (deg),
        .I_TS_DIRECTION (dir),
        .I_TS_SRC_BASE  (src),
        .I_TS_DST_BASE  (dst),
        .I_TS_IRQ_CLR   (irq_clr),
        .O_TS_BUSY      (busy),
        .O_TS_IRQ       (irq),
        .O_TS_ERR       (err),
        .O_TS_TILE_X    (tile_x),
        .O_TS_TILE_Y    (tile_y),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Responder state and captured transactions
    int rd_dly = 0, core_dly = 0, wr_dly = 0;
    bit noise = 1'b0;
    logic [31:0] rd_q[$], wr_q[$];
    int          txq[$], tyq[$];
    logic [2:0]  cfgq[$];
    int core_pulses = 0, stab_err = 0;

    // Expected transactions from the model
    logic [31:0] exp_rd[$], exp_wr[$];
    int          exp_tx[$], exp_ty[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Bus / core responder with per-channel latency and optional stray DONEs.
    initial begin
        bit rd_act, core_act, wr_act, prev_cs;
        int rd_cnt, core_cnt, wr_cnt;
        rd_act = 0; core_act = 0; wr_act = 0; prev_cs = 0;
        rd_cnt = 0; core_cnt = 0; wr_cnt = 0;
        bus.I_TS_RD_DONE = 1'b0;
        bus.I_TS_CORE_DONE = 1'b0;
        bus.I_TS_WR_DONE = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.I_TS_RD_DONE = 1'b0;
                bus.I_TS_CORE_DONE = 1'b0;
                bus.I_TS_WR_DONE = 1'b0;
                rd_act = 0; core_act = 0; wr_act = 0; prev_cs = 0;
            end else begin
                if (bus.O_TS_RD_REQ) begin
                    if (!rd_act) begin
                        rd_act = 1; rd_cnt = 0;
                        rd_q.push_back(bus.O_TS_RD_ADDR);
                        txq.push_back(int'(tile_x));
                        tyq.push_back(int'(tile_y));
                    end else if (bus.O_TS_RD_ADDR !== rd_q[$]) stab_err++;
                    bus.I_TS_RD_DONE = (rd_cnt == rd_dly);
                    rd_cnt++;
                end else begin
                    rd_act = 0;
                    bus.I_TS_RD_DONE = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                end

                if (bus.O_TS_CORE_START) begin
                    if (prev_cs) stab_err++;
                    core_pulses++;
                    core_act = 1; core_cnt = 0;
                    cfgq.push_back({bus.O_TS_CORE_DIRECTION, bus.O_TS_CORE_DEGREES});
                end
                prev_cs = bus.O_TS_CORE_START;
                if (core_act && bus.O_TS_WR_REQ) core_act = 0;
                if (core_act) begin
                    bus.I_TS_CORE_DONE = (core_cnt == core_dly);
                    core_cnt++;
                end else begin
                    bus.I_TS_CORE_DONE = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                end

                if (bus.O_TS_WR_REQ) begin
                    if (!wr_act) begin
                        wr_act = 1; wr_cnt = 0;
                        wr_q.push_back(bus.O_TS_WR_ADDR);
                    end else if (bus.O_TS_WR_ADDR !== wr_q[$]) stab_err++;
                    bus.I_TS_WR_DONE = (wr_cnt == wr_dly);
                    wr_cnt++;
                end else begin
                    wr_act = 0;
                    bus.I_TS_WR_DONE = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end
        end
    end

    // Reference model: rotate the tile's two extreme pixel corners as image
    // coordinates, one clockwise quarter turn at a time, and take the
    // bounding box of the result as the destination tile.
    task automatic build_model(input int w, input int h, input logic [1:0] dg, input logic dr,
                               input logic [31:0] s, input logic [31:0] d);
        int tw, th, r;
        tw = w / 8; th = h / 8;
        r = dr ? (4 - int'(dg)) % 4 : int'(dg);
        exp_rd.delete(); exp_wr.delete(); exp_tx.delete(); exp_ty.delete();
        for (int k = 0; k < tw * th; k++) begin
            int tx, ty, ax, ay, bx, by, cw, ch, t, mx, my;
            tx = k % tw; ty = k / tw;
            ax = tx * 8; ay = ty * 8; bx = ax + 7; by = ay + 7;
            cw = w; ch = h;
            for (int i = 0; i < r; i++) begin
                t = ax; ax = ch - 1 - ay; ay = t;
                t = bx; bx = ch - 1 - by; by = t;
                t = cw; cw = ch; ch = t;
            end
            mx = (ax < bx) ? ax : bx;
            my = (ay < by) ? ay : by;
            exp_tx.push_back(tx);
            exp_ty.push_back(ty);
            exp_rd.push_back(32'(longint'(s) + longint'(ty * 8 * w + tx * 8) * 3));
            exp_wr.push_back(32'(longint'(d) + longint'(my * cw + mx) * 3));
        end
    endtask

    task automatic run_job(input vec_t v, input bit hold_clr);
        int n, budget;
        rd_q.delete(); wr_q.delete(); txq.delete(); tyq.delete(); cfgq.delete();
        core_pulses = 0; stab_err = 0;
        rd_dly = v.dly; core_dly = v.dly; wr_dly = v.dly;
        build_model(v.w, v.h, v.deg, v.dir, v.src, v.dst);
        budget = 40 * exp_rd.size() + 100;
        width = 16'(v.w); height = 16'(v.h); deg = v.deg; dir = v.dir;
        src = v.src; dst = v.dst;
        irq_clr = hold_clr;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("err_after_start", 64'(err), 64'd0);
        // Config inputs must be ignored once the job is running
        width = 16'($urandom); height = 16'($urandom); deg = 2'($urandom); dir = 1'($urandom);
        src = $urandom; dst = $urandom;
        n = 0;
        while (!irq && n < budget) begin
            start = (n == 3);
            tick();
            n++;
        end
        start = 1'b0;
        chk("irq_at_job_end", 64'(irq), 64'd1);
        chk("busy_at_job_end", 64'(busy), 64'd0);
        chk("rd_count", 64'(rd_q.size()), 64'(exp_rd.size()));
        chk("wr_count", 64'(wr_q.size()), 64'(exp_wr.size()));
        chk("core_pulses", 64'(core_pulses), 64'(exp_rd.size()));
        chk("handshake_stable", 64'(stab_err), 64'd0);
        for (int i = 0; i < exp_rd.size(); i++) begin
            if (i < rd_q.size()) begin
                chk($sformatf("rd_addr[%0d]", i), 64'(rd_q[i]), 64'(exp_rd[i]));
                chk($sformatf("tile_x[%0d]", i), 64'(txq[i]), 64'(exp_tx[i]));
                chk($sformatf("tile_y[%0d]", i), 64'(tyq[i]), 64'(exp_ty[i]));
            end
            if (i < wr_q.size())
                chk($sformatf("wr_addr[%0d]", i), 64'(wr_q[i]), 64'(exp_wr[i]));
            if (i < cfgq.size())
                chk($sformatf("core_cfg[%0d]", i), 64'(cfgq[i]), 64'({v.dir, v.deg}));
        end
        for (int i = 0; i < v.nexp; i++) begin
            if (i < rd_q.size()) chk($sformatf("tbl_rd[%0d]", i), 64'(rd_q[i]), 64'(v.erd[i]));
            if (i < wr_q.size()) chk($sformatf("tbl_wr[%0d]", i), 64'(wr_q[i]), 64'(v.ewr[i]));
        end
        if (hold_clr) begin
            tick();
            irq_clr = 1'b0;
            chk("irq_clr_after_set", 64'(irq), 64'd0);
        end else begin
            tick();
            tick();
            chk("irq_level_held", 64'(irq), 64'd1);
            irq_clr = 1'b1;
            tick();
            irq_clr = 1'b0;
            chk("irq_cleared", 64'(irq), 64'd0);
        end
    endtask

    function automatic vec_t mk(input int w, input int h, input logic [1:0] dg, input logic dr,
                                input logic [31:0] s, input logic [31:0] d, input int dl, input int ne,
                                input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] r3, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3);
        vec_t v;
        v.w = w; v.h = h; v.deg = dg; v.dir = dr; v.src = s; v.dst = d; v.dly = dl; v.nexp = ne;
        v.erd[0] = r0; v.erd[1] = r1; v.erd[2] = r2; v.erd[3] = r3;
        v.ewr[0] = w0; v.ewr[1] = w1; v.ewr[2] = w2; v.ewr[3] = w3;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({bus.O_TS_RD_REQ, bus.O_TS_CORE_START, bus.O_TS_WR_REQ,
                                 bus.O_TS_CORE_DEGREES, bus.O_TS_CORE_DIRECTION, busy, err,
                                 tile_x, tile_y}), 64'd0);
        chk({tag, "_irq"}, 64'(irq), 64'd0);
        chk({tag, "_rd_addr"}, 64'(bus.O_TS_RD_ADDR), 64'd0);
        chk({tag, "_wr_addr"}, 64'(bus.O_TS_WR_ADDR), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t rv;
        int n;
        vecs[0] = mk(16, 16, 2'd0, 1'b0, 32'h1000, 32'h2000, 2, 4,
                     32'h1000, 32'h1018, 32'h1180, 32'h1198, 32'h2000, 32'h2018, 32'h2180, 32'h2198);
        vecs[1] = mk(16, 8, 2'd1, 1'b0, 32'h0, 32'h0, 1, 2,
                     32'h0, 32'h18, 32'h0, 32'h0, 32'h0, 32'hC0, 32'h0, 32'h0);
        vecs[2] = mk(16, 8, 2'd1, 1'b1, 32'h0, 32'h0, 3, 2,
                     32'h0, 32'h18, 32'h0, 32'h0, 32'hC0, 32'h0, 32'h0, 32'h0);
        vecs[3] = mk(8, 8, 2'd2, 1'b0, 32'h40, 32'h80, 0, 1,
                     32'h40, 32'h0, 32'h0, 32'h0, 32'h80, 32'h0, 32'h0, 32'h0);
        vecs[4] = mk(16, 16, 2'd2, 1'b0, 32'h0, 32'h0, 1, 4,
                     32'h0, 32'h18, 32'h180, 32'h198, 32'h198, 32'h180, 32'h18, 32'h0);
        vecs[5] = mk(2040, 16, 2'd1, 1'b0, 32'h0, 32'h0, 0, 2,
                     32'h0, 32'h18, 32'h0, 32'h0, 32'h18, 32'h198, 32'h0, 32'h0);

        // Reset state
        tick();
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Directed vectors; the single-tile job holds IRQ_CLR through its end
        for (int i = 0; i < 6; i++) run_job(vecs[i], i == 3);

        // Invalid configurations
        rd_q.delete();
        width = 16'd12; height = 16'd8; start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_width12", 64'(err), 64'd1);
        chk("busy_width12", 64'(busy), 64'd0);
        width = 16'd16; height = 16'd2048; start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_height2048", 64'(err), 64'd1);
        repeat (4) tick();
        chk("no_rd_on_err", 64'(rd_q.size()), 64'd0);
        run_job(vecs[1], 1'b0);

        // Reset while tile 2 is in ROT
        rd_q.delete(); wr_q.delete(); txq.delete(); tyq.delete(); cfgq.delete();
        core_pulses = 0; rd_dly = 1; wr_dly = 1; core_dly = 50;
        width = 16'd16; height = 16'd16; deg = 2'd3; dir = 1'b1;
        src = 32'h5000; dst = 32'h6000;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (core_pulses < 2 && n < 400) begin
            tick();
            n++;
        end
        chk("rot_tile2_reached", 64'(core_pulses), 64'd2);
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        chk_all_zero("midjob_reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_job(vecs[0], 1'b0);

        // Randomized jobs with stray DONE pulses outside their states
        noise = 1'b1;
        for (int j = 0; j < 8; j++) begin
            rv = mk(8 * int'($urandom_range(1, 6)), 8 * int'($urandom_range(1, 6)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    int'($urandom_range(0, 3)), 0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
            run_job(rv, 1'($urandom_range(0, 1)));
        end
        noise = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
